// File: rtl/enemy_wave_seq_pkg.sv
// Shared types and constants for the enemy wave sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package enemy_wave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Spawn-jitter LFSR seed and right-shift Galois mask for x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Ceiling log2, used for the slot-index and spawn-counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One Galois LFSR step (shift right, xor taps when the dropped bit is set).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/enemy_wave_seq_if.sv
// Control strobes in, lane state out, for the enemy wave sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; tick/start/hit are strobes, outputs are plain registered levels.
interface enemy_wave_seq_if #(
  parameter int NUM_ENEMY = 4,
  parameter int NUM_POS   = 11,
  parameter int POS_W     = 4
);
  logic                          tick;
  logic                          start;
  logic [NUM_ENEMY-1:0]          hit;
  logic [NUM_ENEMY*POS_W-1:0]    pos;
  logic [NUM_ENEMY-1:0]          alive;
  logic [NUM_POS-1:0]            led_mask;
  logic                          breach;
  logic [7:0]                    breach_cnt;
  logic                          game_over;

  // Game controller side: drives strobes, consumes lane state.
  modport master (
    output tick, start, hit,
    input  pos, alive, led_mask, breach, breach_cnt, game_over
  );

  // Sequencer side.
  modport slave (
    input  tick, start, hit,
    output pos, alive, led_mask, breach, breach_cnt, game_over
  );
endinterface

// File: rtl/enemy_wave_seq_slot_pick.sv
// Picks the first set bit of a free mask, scanning upward from start_idx with wrap.
// Latency: combinational.
// Backpressure: none.
module enemy_slot_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     free,
  input  logic [IDX_W-1:0] start_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Rotating priority scan; the first free candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(start_idx) + k) % N);
      if (!found && free[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/enemy_wave_seq.sv
// Multi-lane enemy sequencer: spawning, stepping, hits, breaches and game-over.
// Latency: 1 cycle, every output is registered from the cycle's next-state values.
// Backpressure: none; tick/start/hit are sampled every cycle and never stalled.
// Optional ENEMY_RAND_SPAWN_EN: LFSR jitter on the spawn period and on the start slot.
module enemy_wave_seq
  import enemy_wave_pkg::*;
#(
  parameter int NUM_ENEMY    = 4,
  parameter int NUM_POS      = 11,
  parameter int POS_W        = 4,
  parameter int SPAWN_PERIOD = 8,
  parameter int MAX_BREACH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  enemy_wave_seq_if.slave  bus
);

  localparam int SLOT_W = (clog2(NUM_ENEMY) < 1) ? 1 : clog2(NUM_ENEMY);
  localparam int CNT_W  = clog2(SPAWN_PERIOD + 4) + 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);
  localparam logic [7:0]       MAX_CNT  = 8'(MAX_BREACH);

  state_t                              state_q, state_n;
  logic [NUM_ENEMY-1:0][POS_W-1:0]     pos_q, pos_n;
  logic [NUM_ENEMY-1:0]                alive_q, alive_n;
  logic [NUM_POS-1:0]                  led_q, led_n;
  logic                                breach_q, breach_n;
  logic [7:0]                          bcnt_q, bcnt_n;
  logic [CNT_W-1:0]                    spawn_cnt_q, spawn_cnt_n;
  logic [CNT_W-1:0]                    spawn_lim;
  logic [NUM_ENEMY-1:0]                breach_vec;
  logic [NUM_ENEMY-1:0]                free_mask;
  logic [8:0]                          bcnt_sum;
  logic [SLOT_W-1:0]                   pick_start, pick_idx;
  logic                                pick_found;
  logic                                spawn_due;

  // Only slots dead at the start of the cycle may be respawned; slots freed
  // this cycle by a hit or breach stay empty until a later spawn.
  assign free_mask = ~alive_q;
  assign spawn_due = (state_q == RUN) && bus.tick && (spawn_cnt_q == spawn_lim);

`ifdef ENEMY_RAND_SPAWN_EN
  logic [7:0]       lfsr_q, lfsr_n;
  logic [CNT_W-1:0] lim_q, lim_n;

  assign spawn_lim  = lim_q;
  assign pick_start = SLOT_W'(int'(lfsr_q[3:2]) % NUM_ENEMY);

  // LFSR steps on every RUN tick; the spawn period picks up 0..3 ticks of jitter
  // from the pre-step LFSR value whenever a spawn attempt reloads the counter.
  always_comb begin
    lfsr_n = lfsr_q;
    lim_n  = lim_q;
    if (state_q == RUN && bus.tick) begin
      lfsr_n = lfsr_step(lfsr_q);
      if (spawn_due) lim_n = CNT_W'(SPAWN_PERIOD - 1) + CNT_W'(lfsr_q[1:0]);
    end else if (state_q != RUN && bus.start) begin
      lim_n = CNT_W'(SPAWN_PERIOD - 1);
    end
  end

  // Jitter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
      lim_q  <= CNT_W'(SPAWN_PERIOD - 1);
    end else begin
      lfsr_q <= lfsr_n;
      lim_q  <= lim_n;
    end
  end
`else
  assign spawn_lim  = CNT_W'(SPAWN_PERIOD - 1);
  assign pick_start = '0;
`endif

  enemy_slot_pick #(
    .N     (NUM_ENEMY),
    .IDX_W (SLOT_W)
  ) u_pick (
    .free      (free_mask),
    .start_idx (pick_start),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  // Next-state: FSM plus per-lane update, hit taking priority over movement.
  always_comb begin
    state_n     = state_q;
    pos_n       = pos_q;
    alive_n     = alive_q;
    bcnt_n      = bcnt_q;
    spawn_cnt_n = spawn_cnt_q;
    breach_vec  = '0;
    bcnt_sum    = '0;
    led_n       = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_n     = RUN;
          pos_n       = '0;
          alive_n     = '0;
          bcnt_n      = '0;
          spawn_cnt_n = '0;
        end
      end

      RUN: begin
        alive_n = alive_q & ~bus.hit;
        if (bus.tick) begin
          for (int i = 0; i < NUM_ENEMY; i++) begin
            if (alive_q[i] && !bus.hit[i]) begin
              if (pos_q[i] == LAST_POS) begin
                alive_n[i]    = 1'b0;
                breach_vec[i] = 1'b1;
              end else begin
                pos_n[i] = pos_q[i] + 1'b1;
              end
            end
          end
          spawn_cnt_n = spawn_due ? '0 : spawn_cnt_q + 1'b1;
        end

        bcnt_sum = {1'b0, bcnt_q};
        for (int i = 0; i < NUM_ENEMY; i++) begin
          bcnt_sum = bcnt_sum + {8'd0, breach_vec[i]};
        end
        bcnt_n = (bcnt_sum >= {1'b0, MAX_CNT}) ? MAX_CNT : bcnt_sum[7:0];

        // Losing the game wins over a spawn that would be cleared anyway.
        if (bcnt_n == MAX_CNT) begin
          state_n = OVER;
          alive_n = '0;
        end else if (spawn_due && pick_found) begin
          alive_n[pick_idx] = 1'b1;
          pos_n[pick_idx]   = '0;
        end
      end

      OVER: begin
        alive_n = '0;
        if (bus.start) begin
          state_n     = RUN;
          pos_n       = '0;
          bcnt_n      = '0;
          spawn_cnt_n = '0;
        end
      end

      default: state_n = IDLE;
    endcase

    for (int i = 0; i < NUM_ENEMY; i++) begin
      if (alive_n[i]) led_n = led_n | (NUM_POS'(1) << pos_n[i]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      alive_q     <= '0;
      led_q       <= '0;
      breach_q    <= 1'b0;
      bcnt_q      <= '0;
      spawn_cnt_q <= '0;
    end else begin
      state_q     <= state_n;
      pos_q       <= pos_n;
      alive_q     <= alive_n;
      led_q       <= led_n;
      breach_q    <= breach_n;
      bcnt_q      <= bcnt_n;
      spawn_cnt_q <= spawn_cnt_n;
    end
  end

  assign breach_n       = |breach_vec;
  assign bus.pos        = pos_q;
  assign bus.alive      = alive_q;
  assign bus.led_mask   = led_q;
  assign bus.breach     = breach_q;
  assign bus.breach_cnt = bcnt_q;
  assign bus.game_over  = (state_q == OVER);

endmodule

// File: doc/enemy_wave_seq.md
Name: enemy_wave_seq

Overview:
- Parametrised successor of the single-enemy position script.
- Drives NUM_ENEMY independent enemy lanes that advance along NUM_POS discrete positions on a step tick.
- Handles periodic spawning, player hits, breaches and game-over.
- Sits between the step clock domain logic and the sprite renderers/compositor; its pos/alive buses feed per-enemy sprite blocks and its LED mask feeds the board LEDs.

Parameters:
- NUM_ENEMY, 4, number of enemy slots.
- NUM_POS, 11, positions per lane (0 = spawn edge, NUM_POS-1 = last before breach).
- POS_W, 4, width of one position field; must satisfy 2**POS_W >= NUM_POS.
- SPAWN_PERIOD, 8, ticks between spawn attempts (>=1).
- MAX_BREACH, 3, breaches that end the game (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle step strobe, synchronous to clk.
- start  in  1  level/pulse; starts or restarts a game.
- hit  in  NUM_ENEMY  per-slot kill request, sampled every cycle.
- pos  out  NUM_ENEMY*POS_W  packed positions; slot i occupies bits [i*POS_W +: POS_W].
- alive  out  NUM_ENEMY  slot occupied.
- led_mask  out  NUM_POS  OR over alive slots of (1 << pos[i]).
- breach  out  1  one-cycle pulse when any enemy leaves the lane.
- breach_cnt  out  8  total breaches this game, saturating at MAX_BREACH.
- game_over  out  1  high in OVER state.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; spawn counter 0; LFSR = 8'hA5.
- FSM IDLE -> RUN on start=1. In IDLE, tick and hit are ignored.
- FSM RUN -> OVER in the cycle breach_cnt becomes MAX_BREACH.
- FSM OVER -> RUN on start=1, with alive, pos, breach_cnt and spawn counter all cleared in that same transition cycle.
- Entering OVER: alive cleared next cycle; pos frozen.
- All outputs are registered: an event sampled in cycle t is visible in t+1. led_mask is registered from the next-state values, so it stays coherent with pos/alive.
- RUN, per cycle, priority hit > move:
  - hit[i] with alive[i]=1 clears alive[i]; no breach; pos[i] holds.
  - hit on a dead slot is ignored.
- RUN, tick=1, for each alive, un-hit slot:
  - pos < NUM_POS-1: pos+1.
  - pos = NUM_POS-1: alive cleared and slot counted as breaching.
  - breach pulses once even when several slots breach in the same tick.
  - breach_cnt adds the number of breaching slots, saturating at MAX_BREACH.
- Spawn counter increments on each RUN tick.
- When the counter = SPAWN_PERIOD-1 on a tick:
  - counter reloads to 0.
  - The lowest-index slot dead at the start of that cycle is spawned: alive=1, pos=0.
  - A slot freed in the same cycle (hit or breach) is not eligible.
  - No free slot: spawn dropped silently, counter still reloads.
- Simultaneous start in RUN is ignored.
- Reset mid-game returns to IDLE immediately.

Optional Feature:
- Macro ENEMY_RAND_SPAWN_EN.
- Defined:
  - 8-bit Galois LFSR (taps 8,6,5,4) advances on every RUN tick.
  - Reload value = SPAWN_PERIOD-1 + lfsr[1:0], giving a 0..3 extra-tick jitter.
  - The spawned slot is the first free slot scanning upward from lfsr[3:2] mod NUM_ENEMY, wrapping.
- Undefined: fixed period and lowest-index slot selection as above; LFSR logic absent.

Decomposition:
- Package enemy_wave_pkg:
  - state enum {IDLE, RUN, OVER}.
  - LFSR_SEED = 8'hA5.
  - LFSR_TAPS constant.
  - Function clog2 for the derived slot-index width.
- One sub-module enemy_slot_pick: combinational, with inputs free mask and start index; outputs found flag and slot index. Shared by the fixed and random modes (start index 0 when the feature is off).

Test Plan:
- Reset then start, 8 ticks, feature off -> slot 0 alive at pos 0 after tick 8; led_mask = 11'h001; pos0 reaches 10 after 10 more ticks; breach on the 11th; breach_cnt=1.
- hit[0] in the same cycle as a tick with pos0=10 -> alive[0]=0; no breach; breach_cnt unchanged.
- SPAWN_PERIOD=1, NUM_ENEMY=4, no hits -> slots 0..3 spawn on consecutive ticks; 5th spawn dropped; alive=4'hF.
- Two enemies at pos 10 on the same tick with breach_cnt=1, MAX_BREACH=3 -> single breach pulse; breach_cnt=3; game_over=1 next cycle; alive=0.
- In OVER, assert start -> RUN; breach_cnt=0; first spawn after SPAWN_PERIOD ticks.
- rst low mid-RUN with alive=4'h5 -> all outputs 0 asynchronously; start ignored until rst high.
- ENEMY_RAND_SPAWN_EN defined, seed 8'hA5 -> spawn intervals and slot indices match the reference LFSR model for 64 ticks.
